decode: RTL and testbench
=========================

Name: decode

Overview:
- Instruction decode stage; sits directly downstream of fetch.
- Consumes fetch's PC and the 32-bit instruction word read from main memory at that PC.
- Reads the 32x32 register file, splits the MIPS fields, extends the immediate and registers everything into the ID/EX pipeline register for execute.
- Detects load-use hazards and drives the stall signal back to fetch.

Parameters:
- NOP_INSN, 32'h00000000, instruction word injected as a bubble.
- RA_REG, 5'd31, destination register for JAL.

Ports:
- clk_in  input  1  stage clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- pc_in  input  32  PC of the instruction presented by fetch.
- insn_in  input  32  instruction word from main memory.
- insn_valid_in  input  1  pc_in/insn_in are a real instruction.
- wb_we_in  input  1  writeback enable.
- wb_addr_in  input  5  writeback register index.
- wb_data_in  input  32  writeback data.
- stall_out  output  1  to fetch stall_in; combinational.
- valid_out  output  1  ID/EX entry valid.
- pc_out  output  32  registered PC.
- opcode_out  output  6  insn[31:26].
- funct_out  output  6  insn[5:0].
- shamt_out  output  5  insn[10:6].
- rs_out  output  5  insn[25:21].
- rt_out  output  5  insn[20:16].
- dest_out  output  5  destination register index.
- reg_write_out  output  1  instruction writes dest_out.
- mem_read_out  output  1  load instruction.
- rs_data_out  output  32  register file value of rs.
- rt_data_out  output  32  register file value of rt.
- imm_out  output  32  extended immediate.
- target_out  output  26  insn[25:0], jump target.

Behaviour:
- Reset (rst_n_in low, asynchronous): all registered outputs 0, valid_out 0, FSM to RUN, hold register cleared, all 32 registers cleared.
- Latency: one clk_in edge from insn_in to the ID/EX outputs.
- Register file: writes at posedge when wb_we_in=1 and wb_addr_in!=0. Writes to r0 are dropped. Register index 0 always reads 0.
- Field rules:
  - dest_out: rd for opcode 0x00; RA_REG for JAL (0x03).
  - dest_out is 0 and reg_write_out is 0 for SW/SB/SH (0x2B/0x28/0x29), BEQ/BNE (0x04/0x05) and J (0x02).
  - dest_out is rt otherwise, with reg_write_out=1.
  - imm_out: zero-extended for ANDI/ORI/XORI (0x0C/0x0D/0x0E); sign-extended insn[15:0] otherwise.
  - mem_read_out=1 for LW/LB/LBU/LH/LHU (0x23/0x20/0x24/0x21/0x25).
- Hazard: hz = valid_out & mem_read_out & dest_out!=0 & (dest_out==cur_rs | dest_out==cur_rt), where cur_rs/cur_rt are the fields of the current instruction. hz drives stall_out.
- FSM states:
  - RUN, stall_out=hz. The current instruction is insn_in/pc_in, counted only if insn_valid_in=1.
    - If hz: capture pc_in/insn_in/insn_valid_in into the hold register, load a bubble into ID/EX (valid_out=0, reg_write_out=0, mem_read_out=0, other fields from NOP_INSN), and go to HOLD.
    - Else: register the decoded current instruction; valid_out=insn_valid_in.
  - HOLD: the current instruction comes from the hold register; insn_in is ignored.
    - stall_out=hz. Because the bubble now sits in ID/EX, hz=0 after one bubble, so stall_out=0.
    - Register the held instruction, then return to RUN.
    - Fetch re-presents the next PC on the following cycle.
- insn_valid_in=0 in RUN: produces a bubble with valid_out=0 and no stall.
- Simultaneous writeback and read of the same register: behaviour depends on the macro below.
- Reset mid-HOLD: the held instruction is discarded and the FSM goes to RUN.

Optional Feature:
- Macro DECODE_WB_BYPASS_EN.
- Defined: if wb_we_in=1, wb_addr_in!=0 and wb_addr_in equals rs (or rt), the corresponding *_data_out captures wb_data_in in the same edge (write-through).
- Undefined: captures the pre-write register value. The pipeline must then schedule writeback at least one cycle before the dependent decode.

Decomposition:
- Shared package `decode_pkg`:
  - opcode constants OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW, OP_SB, OP_SH;
  - FSM state encoding ST_RUN=1'b0, ST_HOLD=1'b1.
- Sub-module `decode_regfile`: 32x32 storage, 2 read ports, 1 write port, asynchronous reset clear, r0 hardwired to zero, bypass under the macro.

Test Plan:
- Reset → write r5=0xDEADBEEF via writeback → insn 0x00A53020 (add r6,r5,r5) → next edge: rs_data_out=rt_data_out=0xDEADBEEF, dest_out=6, reg_write_out=1, valid_out=1.
- Immediate extension: insn 0x2002FFFF (addi) → imm_out=0xFFFFFFFF; insn 0x3402FFFF (ori) → imm_out=0x0000FFFF.
- Load-use: lw r8,0(r1) then add r9,r8,r2 → stall_out=1 for exactly one cycle, one bubble with valid_out=0, then the add is issued with pc_out equal to its PC; no duplicate or lost instruction.
- r0 handling: writeback to r0 with 0x1234 → a later read of r0 returns 0. lw r0 followed by use of r0 → no stall.
- Same-cycle writeback r3=0x55 while decoding a read of r3 → rs_data_out=0x55 with DECODE_WB_BYPASS_EN defined; previous value without it.
- Assert rst_n_in low during HOLD, off-clock-edge → outputs 0 immediately, stall_out=0, state RUN.

Source files
------------

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcode constants, FSM encoding and field-decode helpers for decode
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;

  typedef enum logic {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_t;

  function automatic logic is_no_write(input logic [5:0] op);
    return op inside {OP_SW, OP_SB, OP_SH, OP_BEQ, OP_BNE, OP_J};
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU};
  endfunction

  function automatic logic [31:0] ext_imm(input logic [31:0] insn);
    if (insn[31:26] inside {OP_ANDI, OP_ORI, OP_XORI})
      return {16'h0000, insn[15:0]};
    return {{16{insn[15]}}, insn[15:0]};
  endfunction

  function automatic logic [4:0] dest_of(input logic [31:0] insn, input logic [4:0] ra);
    if (insn[31:26] == OP_RTYPE)   return insn[15:11];
    if (insn[31:26] == OP_JAL)     return ra;
    if (is_no_write(insn[31:26]))  return 5'd0;
    return insn[20:16];
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - 32x32 register file, 2 async read ports, 1 write port; DECODE_WB_BYPASS_EN enables write-through reads
module decode_regfile
  import decode_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr_a,
  input  logic [4:0]  i_raddr_b,
  output logic [31:0] o_rdata_a,
  output logic [31:0] o_rdata_b
);

  logic [31:0] r_regs [32];
  logic        w_wr_en;

  assign w_wr_en = i_we && (i_waddr != 5'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  function automatic logic [31:0] read_port(input logic [4:0] addr);
    if (addr == 5'd0) return 32'h0;
`ifdef DECODE_WB_BYPASS_EN
    if (w_wr_en && (i_waddr == addr)) return i_wdata;
`endif
    return r_regs[addr];
  endfunction

  assign o_rdata_a = read_port(i_raddr_a);
  assign o_rdata_b = read_port(i_raddr_b);

endmodule

// File: rtl/decode.sv
// rtl/decode.sv - MIPS decode stage with ID/EX register and load-use stall; honours DECODE_WB_BYPASS_EN via decode_regfile
module decode
  import decode_pkg::*;
#(
  parameter logic [31:0] NOP_INSN = 32'h00000000,
  parameter logic [4:0]  RA_REG   = 5'd31
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] insn_in,
  input  logic        insn_valid_in,
  input  logic        wb_we_in,
  input  logic [4:0]  wb_addr_in,
  input  logic [31:0] wb_data_in,
  output logic        stall_out,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [5:0]  opcode_out,
  output logic [5:0]  funct_out,
  output logic [4:0]  shamt_out,
  output logic [4:0]  rs_out,
  output logic [4:0]  rt_out,
  output logic [4:0]  dest_out,
  output logic        reg_write_out,
  output logic        mem_read_out,
  output logic [31:0] rs_data_out,
  output logic [31:0] rt_data_out,
  output logic [31:0] imm_out,
  output logic [25:0] target_out
);

  state_t      r_state, w_state_next;
  logic [31:0] r_hold_pc, r_hold_insn;
  logic        r_hold_valid;

  logic [31:0] w_cur_pc, w_cur_insn, w_sel_insn;
  logic        w_cur_valid, w_hz, w_issue, w_capture;
  logic [31:0] w_rs_data, w_rt_data;

  assign w_cur_pc    = (r_state == ST_HOLD) ? r_hold_pc    : pc_in;
  assign w_cur_insn  = (r_state == ST_HOLD) ? r_hold_insn  : insn_in;
  assign w_cur_valid = (r_state == ST_HOLD) ? r_hold_valid : insn_valid_in;

  // Only a real current instruction can depend on the load sitting in ID/EX.
  assign w_hz = valid_out && mem_read_out && (dest_out != 5'd0) && w_cur_valid &&
                ((dest_out == w_cur_insn[25:21]) || (dest_out == w_cur_insn[20:16]));
  assign stall_out = w_hz;

  decode_regfile u_regfile (
    .i_clk     (clk_in),
    .i_rst_n   (rst_n_in),
    .i_we      (wb_we_in),
    .i_waddr   (wb_addr_in),
    .i_wdata   (wb_data_in),
    .i_raddr_a (w_cur_insn[25:21]),
    .i_raddr_b (w_cur_insn[20:16]),
    .o_rdata_a (w_rs_data),
    .o_rdata_b (w_rt_data)
  );

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_hz) begin
          w_capture    = 1'b1;
          w_state_next = ST_HOLD;
        end else begin
          w_issue = w_cur_valid;
        end
      end
      ST_HOLD: begin
        w_issue      = w_cur_valid && !w_hz;
        w_state_next = w_hz ? ST_HOLD : ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  assign w_sel_insn = w_issue ? w_cur_insn : NOP_INSN;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state       <= ST_RUN;
      r_hold_pc     <= '0;
      r_hold_insn   <= '0;
      r_hold_valid  <= 1'b0;
      valid_out     <= 1'b0;
      pc_out        <= '0;
      opcode_out    <= '0;
      funct_out     <= '0;
      shamt_out     <= '0;
      rs_out        <= '0;
      rt_out        <= '0;
      dest_out      <= '0;
      reg_write_out <= 1'b0;
      mem_read_out  <= 1'b0;
      rs_data_out   <= '0;
      rt_data_out   <= '0;
      imm_out       <= '0;
      target_out    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_hold_pc    <= pc_in;
        r_hold_insn  <= insn_in;
        r_hold_valid <= insn_valid_in;
      end
      valid_out     <= w_issue;
      pc_out        <= w_issue ? w_cur_pc : 32'h0;
      opcode_out    <= w_sel_insn[31:26];
      funct_out     <= w_sel_insn[5:0];
      shamt_out     <= w_sel_insn[10:6];
      rs_out        <= w_sel_insn[25:21];
      rt_out        <= w_sel_insn[20:16];
      dest_out      <= dest_of(w_sel_insn, RA_REG);
      reg_write_out <= w_issue && !is_no_write(w_sel_insn[31:26]);
      mem_read_out  <= w_issue && is_load(w_sel_insn[31:26]);
      rs_data_out   <= w_issue ? w_rs_data : 32'h0;
      rt_data_out   <= w_issue ? w_rt_data : 32'h0;
      imm_out       <= ext_imm(w_sel_insn);
      target_out    <= w_sel_insn[25:0];
    end
  end

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - scoreboard bench for decode; expectations follow DECODE_WB_BYPASS_EN when defined
module tb_decode;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [31:0] pc_in, insn_in, wb_data_in;
  logic        insn_valid_in, wb_we_in;
  logic [4:0]  wb_addr_in;
  logic        stall_out, valid_out, reg_write_out, mem_read_out;
  logic [31:0] pc_out, rs_data_out, rt_data_out, imm_out;
  logic [5:0]  opcode_out, funct_out;
  logic [4:0]  shamt_out, rs_out, rt_out, dest_out;
  logic [25:0] target_out;

  always #5 clk_in = ~clk_in;

  decode dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .pc_in         (pc_in),
    .insn_in       (insn_in),
    .insn_valid_in (insn_valid_in),
    .wb_we_in      (wb_we_in),
    .wb_addr_in    (wb_addr_in),
    .wb_data_in    (wb_data_in),
    .stall_out     (stall_out),
    .valid_out     (valid_out),
    .pc_out        (pc_out),
    .opcode_out    (opcode_out),
    .funct_out     (funct_out),
    .shamt_out     (shamt_out),
    .rs_out        (rs_out),
    .rt_out        (rt_out),
    .dest_out      (dest_out),
    .reg_write_out (reg_write_out),
    .mem_read_out  (mem_read_out),
    .rs_data_out   (rs_data_out),
    .rt_data_out   (rt_data_out),
    .imm_out       (imm_out),
    .target_out    (target_out)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_regs [32];
  logic        m_hold;
  logic [31:0] m_hold_pc, m_hold_insn;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_we_in && wb_addr_in == a) return wb_data_in;
`endif
    return m_regs[a];
  endfunction

  function automatic exp_t bubble();
    exp_t e;
    e = '{v:1'b0, pc:32'h0, op:6'h0, dest:5'd0, rw:1'b0, mr:1'b0, rsd:32'h0, rtd:32'h0, imm:32'h0};
    return e;
  endfunction

  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] insn);
    exp_t e;
    logic [5:0] op;
    op     = insn[31:26];
    e      = bubble();
    e.v    = 1'b1;
    e.pc   = pc;
    e.op   = op;
    e.rsd  = rd_model(insn[25:21]);
    e.rtd  = rd_model(insn[20:16]);
    e.rw   = 1'b1;
    case (op)
      6'h00:                                   e.dest = insn[15:11];
      6'h03:                                   e.dest = 5'd31;
      6'h2B, 6'h28, 6'h29, 6'h04, 6'h05, 6'h02: begin e.dest = 5'd0; e.rw = 1'b0; end
      default:                                 e.dest = insn[20:16];
    endcase
    e.mr  = (op == 6'h23) || (op == 6'h20) || (op == 6'h24) || (op == 6'h21) || (op == 6'h25);
    e.imm = ((op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E)) ? {16'h0, insn[15:0]}
                                                             : {{16{insn[15]}}, insn[15:0]};
    return e;
  endfunction

  task automatic set_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_we_in   = we;
    wb_addr_in = a;
    wb_data_in = d;
  endtask

  task automatic step(input logic [31:0] pc, input logic [31:0] insn, input logic v,
                      input logic exp_stall);
    exp_t e;
    pc_in         = pc;
    insn_in       = insn;
    insn_valid_in = v;
    #1;
    check("stall_out", {31'h0, stall_out}, {31'h0, exp_stall});
    if (m_hold) begin
      sb_q.push_back(model(m_hold_pc, m_hold_insn));
      m_hold = 1'b0;
    end else if (exp_stall) begin
      sb_q.push_back(bubble());
      m_hold      = 1'b1;
      m_hold_pc   = pc;
      m_hold_insn = insn;
    end else if (!v) begin
      sb_q.push_back(bubble());
    end else begin
      sb_q.push_back(model(pc, insn));
    end
    @(posedge clk_in);
    if (wb_we_in && wb_addr_in != 5'd0) m_regs[wb_addr_in] = wb_data_in;
    #1;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'h0, 32'h1);
    end else begin
      e = sb_q.pop_front();
      check("valid_out",  {31'h0, valid_out},     {31'h0, e.v});
      check("pc_out",     pc_out,                 e.pc);
      check("opcode_out", {26'h0, opcode_out},    {26'h0, e.op});
      check("dest_out",   {27'h0, dest_out},      {27'h0, e.dest});
      check("reg_write",  {31'h0, reg_write_out}, {31'h0, e.rw});
      check("mem_read",   {31'h0, mem_read_out},  {31'h0, e.mr});
      check("rs_data",    rs_data_out,            e.rsd);
      check("rt_data",    rt_data_out,            e.rtd);
      check("imm_out",    imm_out,                e.imm);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", {31'h0, valid_out},  32'h0);
    check("rst_stall", {31'h0, stall_out},  32'h0);
    check("rst_pc",    pc_out,              32'h0);
    check("rst_dest",  {27'h0, dest_out},   32'h0);
    check("rst_mr",    {31'h0, mem_read_out}, 32'h0);
    check("rst_rsd",   rs_data_out,         32'h0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_hold = 1'b0; m_hold_pc = '0; m_hold_insn = '0;
    rst_n_in = 1'b0;
    pc_in = '0; insn_in = '0; insn_valid_in = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0);
    #2;
    check_reset_outputs();
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;

    set_wb(1'b1, 5'd5, 32'hDEADBEEF);
    step(32'h0, 32'h0, 1'b0, 1'b0);
    set_wb(1'b0, 5'd0, 32'h0);
    step(32'h100, 32'h00A53020, 1'b1, 1'b0);   // add r6,r5,r5
    step(32'h104, 32'h2002FFFF, 1'b1, 1'b0);   // addi
    step(32'h108, 32'h3402FFFF, 1'b1, 1'b0);   // ori
    step(32'h10C, 32'h30428000, 1'b1, 1'b0);   // andi zero-ext
    step(32'h110, 32'h0C000010, 1'b1, 1'b0);   // jal
    step(32'h114, 32'h10A50003, 1'b1, 1'b0);   // beq

    set_wb(1'b1, 5'd0, 32'h1234);
    step(32'h0, 32'h0, 1'b0, 1'b0);
    set_wb(1'b0, 5'd0, 32'h0);
    step(32'h118, 32'h00003820, 1'b1, 1'b0);   // add r7,r0,r0
    step(32'h11C, 32'h8C200000, 1'b1, 1'b0);   // lw r0
    step(32'h120, 32'h00024820, 1'b1, 1'b0);   // use r0, no stall

    step(32'h200, 32'h8C280000, 1'b1, 1'b0);   // lw r8
    step(32'h204, 32'h01024820, 1'b1, 1'b1);   // add r9,r8,r2 stalls
    step(32'h0000DEAD, 32'hFFFFFFFF, 1'b1, 1'b0);
    step(32'h208, 32'hAC2A0000, 1'b1, 1'b0);   // sw
    step(32'h20C, 32'h8C280000, 1'b0, 1'b0);   // invalid load is a bubble
    step(32'h210, 32'h01024820, 1'b1, 1'b0);

    set_wb(1'b1, 5'd3, 32'h11);
    step(32'h0, 32'h0, 1'b0, 1'b0);
    set_wb(1'b1, 5'd3, 32'h55);
    step(32'h400, 32'h00602020, 1'b1, 1'b0);   // same-cycle read of r3
    set_wb(1'b0, 5'd0, 32'h0);
    step(32'h404, 32'h00632020, 1'b1, 1'b0);

    step(32'h300, 32'h8C280000, 1'b1, 1'b0);
    step(32'h304, 32'h01024820, 1'b1, 1'b1);
    #2;
    rst_n_in = 1'b0;
    #1;
    check_reset_outputs();
    m_hold = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    step(32'h308, 32'h00024820, 1'b1, 1'b0);
    step(32'h30C, 32'h00A53020, 1'b1, 1'b0);

    check("sb_drained", sb_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
